pkt_flit_buffer: RTL
====================

// Module: pkt_flit_buffer
// PURPOSE
//  Credit-based flit FIFO between a packet source (ddma send side) and a packet sink (router local port or ddma recv side).
//  Parses packet framing on both sides: header flit, size flit, then <size> payload flits.
//  Supports store-and-forward (release only whole packets) or cut-through. Reports occupancy, whole-packet count and sticky errors.
// PARAMETERS
//  FLIT_WIDTH   32   flit/data width in bits
//  DEPTH        16   FIFO entries; power of two, >= 4
//  STORE_FWD    1    1: out_tx only when >=1 complete packet is buffered; 0: cut-through
//  MAX_PAYLOAD  12   max size-flit value; DEPTH >= MAX_PAYLOAD+2 (elaboration $error otherwise)
// PORTS
//  clock        in   1           single clock, all logic posedge
//  reset        in   1           synchronous, active-low: state clears on a posedge with reset==0
//  in_rx        in   1           source presents a flit this cycle
//  in_data      in   FLIT_WIDTH  source flit
//  in_credit    out  1           buffer can absorb a flit presented next cycle
//  out_tx       out  1           flit valid toward sink
//  out_data     out  FLIT_WIDTH  head flit
//  out_credit   in   1           sink accepts head flit this cycle
//  occupancy    out  $clog2(DEPTH)+1  entries held
//  pkt_count    out  $clog2(DEPTH)+1  complete packets held (tail pushed, header not yet popped)
//  err_oversize out  1           sticky: size flit > MAX_PAYLOAD seen
//  err_overflow out  1           sticky: push attempted while full (flit dropped)
//  clear_err    in   1           1-cycle pulse clears both sticky errors
// BEHAVIOUR
//  Reset: occupancy=0, pkt_count=0, both errors=0, out_tx=0, out_data=0, in_credit=0; both framing FSMs -> HDR.
//  Push: in_rx==1 and not full writes in_data at tail. Occupancy updates the next cycle.
//  Push while full: data is discarded, err_overflow is set, framing FSM does not advance.
//  in_credit is registered: in_credit <= (DEPTH - occupancy_next) >= 2. This covers the source's one-cycle rx lag after sampling credit.
//  Pop: out_tx && out_credit removes the head. out_data = head when occupancy>0, else 0. Zero-latency valid/ready.
//  out_tx, cut-through (STORE_FWD=0): occupancy>0.
//  out_tx, store-and-forward: occupancy>0 && (pkt_count>0 || rd_state!=HDR || release_pending). Mid-packet pops continue once the header is gone.
//  Push framing FSM (wr_state): HDR -push-> SIZE -push-> PAY (load wr_left=size) or HDR if size==0. PAY -push, wr_left==1-> HDR.
//   Tail push (size flit with size 0, or last payload flit): pkt_count +1.
//   Size > MAX_PAYLOAD: set err_oversize and release_pending=1; the packet streams cut-through; release_pending clears when its header pops.
//  Pop framing FSM (rd_state): HDR -> SIZE -> PAY, mirroring the push FSM with rd_left. Header pop of a counted packet: pkt_count -1.
//  Same-cycle tail push and counted header pop: pkt_count unchanged. Same-cycle push and pop: occupancy unchanged.
//  Push and pop are legal on the same cycle when full, provided a pop occurs; no overflow in that case.
//  Pointers are $clog2(DEPTH) bits, wrap naturally. Occupancy is an explicit counter, never pointer difference.
//  Size flit: low 16 bits are the count; upper bits ignored.
//  clear_err and a new error in the same cycle: error remains set.
//  Reset mid-packet: FIFO flushed, partial packet lost, both FSMs to HDR, in_credit 0 for the reset cycle.
// STRUCTURE
//  pkt_sim_pkg: frame_state_t {HDR, SIZE, PAY} as one-hot logic[2:0]; SIZE_FIELD_W=16.
//  Sub-module flit_fifo #(FLIT_WIDTH, DEPTH): storage, pointers, occupancy, full/empty.
//  This block adds the framing FSMs, pkt_count, credit and errors.
// TESTING
//  1. Reset, then push H=0x0001, S=0x0003, P=A,B,C with out_credit=0 -> pkt_count=1 after the C push, occupancy=5, out_tx=1.
//  2. STORE_FWD=1, push H,S=3,A only -> out_tx=0. Push B,C -> out_tx rises the cycle after the C push.
//     Drain -> output order H,3,A,B,C and pkt_count=0 after the H pop.
//  3. Fill DEPTH=16 with out_credit=0 -> in_credit=0 once occupancy>=15. Force a 17th rx -> err_overflow=1, occupancy stays 16.
//  4. Size flit 0x00000000 -> packet counts after 2 flits. Two back-to-back such packets -> pkt_count=2, wr_state=HDR.
//  5. Size 0x20 > MAX_PAYLOAD -> err_oversize=1, out_tx=1 with STORE_FWD=1 before the tail. clear_err -> 0 next cycle.
//  6. Continuous push+pop at 1 flit/cycle across pointer wrap, 40 flits -> occupancy constant, data order preserved.
//     Assert reset mid-packet -> all outputs at reset values.

Source files
------------

// File: rtl/pkt_sim_pkg.sv
// Shared framing definitions for the packet flit buffer.
//   frame_state_t  : one-hot framing state (header, size, payload)
//   SIZE_FIELD_W   : width of the count field in a size flit (low bits)
//   frame_advance  : next framing state after one flit moves through a side
//   frame_is_tail  : true when the flit moving now is the packet's last flit
package pkt_sim_pkg;

    localparam int SIZE_FIELD_W = 16;

    typedef enum logic [2:0] {
        HDR  = 3'b001,
        SIZE = 3'b010,
        PAY  = 3'b100
    } frame_state_t;

    function automatic frame_state_t frame_advance(
        input frame_state_t              cur,
        input logic [SIZE_FIELD_W-1:0]   size_fld,
        input logic [SIZE_FIELD_W-1:0]   left
    );
        frame_state_t nxt;
        case (cur)
            HDR:     nxt = SIZE;
            SIZE:    nxt = (size_fld == '0) ? HDR : PAY;
            PAY:     nxt = (left == SIZE_FIELD_W'(1)) ? HDR : PAY;
            default: nxt = HDR;
        endcase
        return nxt;
    endfunction

    function automatic logic frame_is_tail(
        input frame_state_t              cur,
        input logic [SIZE_FIELD_W-1:0]   size_fld,
        input logic [SIZE_FIELD_W-1:0]   left
    );
        return ((cur == SIZE) && (size_fld == '0)) ||
               ((cur == PAY)  && (left == SIZE_FIELD_W'(1)));
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit storage for pkt_flit_buffer: circular buffer with an explicit
// occupancy counter.
//   clock, reset      : posedge clock, synchronous active-low reset
//   wr_en, wr_data    : push request (ignored when full unless popping)
//   rd_en             : pop request (ignored when empty)
//   rd_data           : head flit, zero when empty
//   occupancy         : entries held
//   occupancy_next    : value occupancy takes at the next edge
//   full, empty       : status flags
module flit_fifo #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [FLIT_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [FLIT_WIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [$clog2(DEPTH):0]  occupancy_next,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (occupancy == OW'(DEPTH));
    assign empty = (occupancy == '0);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign occupancy_next = occupancy + OW'(do_wr) - OW'(do_rd);
    assign rd_data        = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            occupancy <= occupancy_next;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pkt_flit_buffer.sv
// Credit-based flit FIFO between a packet source and a packet sink. Both
// sides parse framing (header, size, <size> payload flits) so the buffer can
// count whole packets and, in store-and-forward mode, release only complete
// packets. Oversized packets cannot fit, so they are streamed cut-through.
//   clock, reset   : posedge clock, synchronous active-low reset
//   in_rx, in_data : source flit strobe and data
//   in_credit      : registered; buffer can absorb a flit presented next cycle
//   out_tx         : head flit valid toward sink
//   out_data       : head flit (zero when empty)
//   out_credit     : sink accepts head flit this cycle
//   occupancy      : entries held
//   pkt_count      : complete packets held whose header has not been popped
//   err_oversize   : sticky, size flit above MAX_PAYLOAD seen
//   err_overflow   : sticky, push attempted while full (flit dropped)
//   clear_err      : pulse clearing both sticky errors
module pkt_flit_buffer
    import pkt_sim_pkg::*;
#(
    parameter int FLIT_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int STORE_FWD   = 1,
    parameter int MAX_PAYLOAD = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_rx,
    input  logic [FLIT_WIDTH-1:0]   in_data,
    output logic                    in_credit,
    output logic                    out_tx,
    output logic [FLIT_WIDTH-1:0]   out_data,
    input  logic                    out_credit,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    err_oversize,
    output logic                    err_overflow,
    input  logic                    clear_err
);

    localparam int OW = $clog2(DEPTH) + 1;

    if (DEPTH < MAX_PAYLOAD + 2) begin : g_depth_check
        $error("pkt_flit_buffer: DEPTH must be >= MAX_PAYLOAD+2");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_pow2_check
        $error("pkt_flit_buffer: DEPTH must be a power of two >= 4");
    end

    logic          full;
    logic          empty;
    logic [OW-1:0] occ_next;
    logic          pop;
    logic          push_ok;
    logic          overflow;

    logic [SIZE_FIELD_W-1:0] wr_size;
    logic [SIZE_FIELD_W-1:0] rd_size;

    frame_state_t            wr_state, wr_state_next;
    logic [SIZE_FIELD_W-1:0] wr_left,  wr_left_next;
    frame_state_t            rd_state, rd_state_next;
    logic [SIZE_FIELD_W-1:0] rd_left,  rd_left_next;

    logic          tail_push;
    logic          oversize_push;
    logic          hdr_pop;
    logic          counted_pop;
    logic          own_hdr_pop;
    logic          tail_counts;
    logic [OW-1:0] pkt_count_next;
    logic          hdr_gone;
    logic          release_pending;
    logic [OW-1:0] rel_skip;
    logic          rel_set;
    logic          rel_done;

    flit_fifo #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock          (clock),
        .reset          (reset),
        .wr_en          (push_ok),
        .wr_data        (in_data),
        .rd_en          (pop),
        .rd_data        (out_data),
        .occupancy      (occupancy),
        .occupancy_next (occ_next),
        .full           (full),
        .empty          (empty)
    );

    assign pop      = out_tx && out_credit;
    assign push_ok  = in_rx && (!full || pop);
    assign overflow = in_rx && full && !pop;

    assign wr_size = in_data[SIZE_FIELD_W-1:0];
    assign rd_size = out_data[SIZE_FIELD_W-1:0];

    always_comb begin
        if (STORE_FWD == 0) begin
            out_tx = !empty;
        end else begin
            out_tx = !empty && ((pkt_count != '0) || (rd_state != HDR) || release_pending);
        end
    end

    // Push-side framing
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_state <= HDR;
            wr_left  <= '0;
        end else begin
            wr_state <= wr_state_next;
            wr_left  <= wr_left_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        wr_left_next  = wr_left;
        tail_push     = 1'b0;
        oversize_push = 1'b0;
        if (push_ok) begin
            wr_state_next = frame_advance(wr_state, wr_size, wr_left);
            tail_push     = frame_is_tail(wr_state, wr_size, wr_left);
            case (wr_state)
                SIZE: begin
                    wr_left_next  = wr_size;
                    oversize_push = (wr_size > SIZE_FIELD_W'(MAX_PAYLOAD));
                end
                PAY:     wr_left_next = wr_left - SIZE_FIELD_W'(1);
                default: ;
            endcase
        end
    end

    // Pop-side framing
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_state <= HDR;
            rd_left  <= '0;
        end else begin
            rd_state <= rd_state_next;
            rd_left  <= rd_left_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_left_next  = rd_left;
        if (pop) begin
            rd_state_next = frame_advance(rd_state, rd_size, rd_left);
            case (rd_state)
                SIZE:    rd_left_next = rd_size;
                PAY:     rd_left_next = rd_left - SIZE_FIELD_W'(1);
                default: ;
            endcase
        end
    end

    // Complete packets leave the FIFO in order, so a header popped while
    // pkt_count is zero belongs to the packet still being written. That
    // packet's tail must then not be counted (hdr_gone remembers this).
    assign hdr_pop        = pop && (rd_state == HDR);
    assign counted_pop    = hdr_pop && (pkt_count != '0);
    assign own_hdr_pop    = hdr_pop && (pkt_count == '0);
    assign tail_counts    = tail_push && !hdr_gone && !own_hdr_pop;
    assign pkt_count_next = pkt_count + OW'(tail_counts) - OW'(counted_pop);

    // rel_skip counts complete packets queued ahead of the oversized one, so
    // the release ends exactly at that packet's header. A second oversized
    // packet arriving while one is still pending waits for its own tail.
    assign rel_set  = oversize_push && !hdr_gone && !own_hdr_pop;
    assign rel_done = release_pending && hdr_pop && (rel_skip == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pkt_count       <= '0;
            hdr_gone        <= 1'b0;
            release_pending <= 1'b0;
            rel_skip        <= '0;
        end else begin
            pkt_count <= pkt_count_next;
            if (tail_push) begin
                hdr_gone <= 1'b0;
            end else if (own_hdr_pop) begin
                hdr_gone <= 1'b1;
            end
            if (rel_set && (!release_pending || rel_done)) begin
                release_pending <= 1'b1;
                rel_skip        <= pkt_count_next;
            end else if (rel_done) begin
                release_pending <= 1'b0;
            end else if (release_pending && hdr_pop) begin
                rel_skip <= rel_skip - OW'(1);
            end
        end
    end

    // Credit looks one flit ahead to cover the source's rx lag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            in_credit <= 1'b0;
        end else begin
            in_credit <= ((OW'(DEPTH) - occ_next) >= OW'(2));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_oversize <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_oversize <= oversize_push || (err_oversize && !clear_err);
            err_overflow <= overflow      || (err_overflow && !clear_err);
        end
    end

endmodule
